// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Requests a 16-bit word at pc, issues it to the control unit with a one-cycle
// run pulse, then waits for done before advancing pc. The word 16'hFFFF parks
// the block in HALT until reset.
// Optional build macro FETCH_TIMEOUT_EN: bounds the wait for mem_valid to
// TIMEOUT cycles. A timeout halts the block and raises fetch_err.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | parked; waits for start
// REQ       | mem_req high at mem_addr=pc; waits for mem_valid
// ISSUE     | instruction registered; run pulses for this one cycle
// WAIT_DONE | control unit executing; done advances pc
// HALT      | halt word fetched (or timeout); only reset leaves

module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // A zero or negative TIMEOUT would make the timeout compare meaningless.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT must be at least 1");
  end

  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             fetch_err_q;

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Outputs decoded directly from state so they line up with the state cycle.
  assign mem_req  = (state == REQ);
  assign run      = (state == ISSUE);
  assign halted   = (state == HALT);
  assign mem_addr = pc;

  // Sequencer: state, pc, instruction register and optional timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt     <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        REQ: begin
          if (mem_valid) begin
            // The halt word is still captured so software can see why we stopped.
            instruction <= mem_rdata;
            state       <= (mem_rdata == HALT_WORD) ? HALT : ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state       <= HALT;
            fetch_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ISSUE: begin
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (done) begin
            pc <= pc + 1'b1;
            if (start) begin
              state <= REQ;
`ifdef FETCH_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (ADDR_W=8, TIMEOUT=16).
// Outputs are sampled 1ns after each rising edge, then inputs for the next
// edge are driven.

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] instruction;
  logic        run;
  logic        done;
  logic [7:0]  pc;
  logic        halted;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .pc          (pc),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ: return one word immediately, wait one WAIT_DONE cycle, pulse done.
  task automatic fetch_one(input logic [15:0] word);
    mem_valid = 1'b1;
    mem_rdata = word;
    tick();               // ISSUE
    mem_valid = 1'b0;
    tick();               // WAIT_DONE
    done = 1'b1;
    tick();               // REQ or IDLE
    done = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    done      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int run_seen;

    // Reset state
    do_reset();
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_run",       32'(run), 32'd0);
    chk("rst_halted",    32'(halted), 32'd0);
    chk("rst_pc",        32'(pc), 32'd0);
    chk("rst_instr",     32'(instruction), 32'h0000);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);

    // Minimum latency fetch of 16'h2A01 at address 0
    start = 1'b1;
    tick();                                           // cycle 1: REQ
    chk("c1_mem_req",  32'(mem_req), 32'd1);
    chk("c1_mem_addr", 32'(mem_addr), 32'd0);
    chk("c1_run",      32'(run), 32'd0);
    mem_valid = 1'b1;
    mem_rdata = 16'h2A01;
    tick();                                           // cycle 2: ISSUE
    mem_valid = 1'b0;
    chk("c2_run",     32'(run), 32'd1);
    chk("c2_instr",   32'(instruction), 32'h2A01);
    chk("c2_mem_req", 32'(mem_req), 32'd0);
    chk("c2_pc",      32'(pc), 32'd0);
    tick();                                           // WAIT_DONE
    chk("wd_run", 32'(run), 32'd0);
    // mem_valid outside REQ must not touch instruction
    mem_valid = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_valid = 1'b0;
    chk("wd_instr_stable", 32'(instruction), 32'h2A01);
    chk("wd_no_req",       32'(mem_req), 32'd0);

    // done with start=1 -> pc=1, requesting address 1
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("next_pc",       32'(pc), 32'd1);
    chk("next_mem_req",  32'(mem_req), 32'd1);
    chk("next_mem_addr", 32'(mem_addr), 32'd1);

    // Second word, then done with start=0 -> IDLE
    mem_valid = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_valid = 1'b0;
    chk("w2_run",   32'(run), 32'd1);
    chk("w2_instr", 32'(instruction), 32'h1111);
    tick();
    start = 1'b0;
    done  = 1'b1;
    tick();
    chk("stop_mem_req", 32'(mem_req), 32'd0);
    chk("stop_pc",      32'(pc), 32'd2);
    tick();                                           // done in IDLE ignored
    done = 1'b0;
    chk("idle_pc",      32'(pc), 32'd2);
    chk("idle_mem_req", 32'(mem_req), 32'd0);

    // start dropped mid-REQ: the request still completes and issues
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_entered", 32'(mem_req), 32'd1);
    tick();
    chk("req_held", 32'(mem_req), 32'd1);
    mem_valid = 1'b1;
    mem_rdata = 16'h0BAD;
    tick();
    mem_valid = 1'b0;
    chk("req_done_run", 32'(run), 32'd1);
    chk("req_done_pc",  32'(pc), 32'd2);

    // pc wrap: 255 fetches take pc to 0xFF, one more wraps to 0
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) fetch_one(16'h0100 + 16'(i));
    chk("pre_wrap_pc",   32'(pc), 32'hFF);
    chk("pre_wrap_addr", 32'(mem_addr), 32'hFF);
    fetch_one(16'h7777);
    chk("wrap_pc",      32'(pc), 32'h00);
    chk("wrap_addr",    32'(mem_addr), 32'h00);
    chk("wrap_mem_req", 32'(mem_req), 32'd1);

    // Halt word: HALT, no run, later mem_valid/done ignored
    mem_valid = 1'b1;
    mem_rdata = 16'hFFFF;
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_instr",  32'(instruction), 32'hFFFF);
    mem_rdata = 16'h5555;
    done      = 1'b1;
    run_seen  = 0;
    for (int i = 0; i < 6; i++) begin
      if (run || mem_req || !halted) run_seen++;
      tick();
    end
    mem_valid = 1'b0;
    done      = 1'b0;
    chk("halt_quiet",       32'(run_seen), 32'd0);
    chk("halt_instr_stable", 32'(instruction), 32'hFFFF);
    chk("halt_pc",          32'(pc), 32'h00);
    chk("halt_fetch_err",   32'(fetch_err), 32'd0);

    // Reset out of HALT
    do_reset();
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_instr",  32'(instruction), 32'h0000);

    // Reset during WAIT_DONE with pc=5; a late done is ignored
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) fetch_one(16'h0200 + 16'(i));
    mem_valid = 1'b1;
    mem_rdata = 16'hABCD;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("wd5_pc",    32'(pc), 32'd5);
    chk("wd5_instr", 32'(instruction), 32'hABCD);
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
    done  = 1'b1;
    chk("rwd_mem_req", 32'(mem_req), 32'd0);
    chk("rwd_pc",      32'(pc), 32'd0);
    chk("rwd_instr",   32'(instruction), 32'h0000);
    chk("rwd_run",     32'(run), 32'd0);
    tick();
    done = 1'b0;
    chk("late_done_pc",  32'(pc), 32'd0);
    chk("late_done_req", 32'(mem_req), 32'd0);

    // Reset during REQ discards the in-flight response
    start = 1'b1;
    tick();
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 16'h4321;
    tick();
    reset     = 1'b0;
    mem_valid = 1'b0;
    start     = 1'b0;
    chk("rreq_instr", 32'(instruction), 32'h0000);
    chk("rreq_req",   32'(mem_req), 32'd0);

    // No memory response
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_still_req", 32'(mem_req), 32'd1);
    chk("tmo_not_yet",   32'(fetch_err), 32'd0);
    tick();
    chk("tmo_halted",    32'(halted), 32'd1);
    chk("tmo_fetch_err", 32'(fetch_err), 32'd1);
    chk("tmo_mem_req",   32'(mem_req), 32'd0);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("notmo_mem_req",   32'(mem_req), 32'd1);
    chk("notmo_halted",    32'(halted), 32'd0);
    chk("notmo_fetch_err", 32'(fetch_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 8, instruction memory address width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles to wait for mem_valid (used only with FETCH_TIMEOUT_EN).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level enable; high = keep fetching and issuing instructions.
REQ-007 mem_req  out  1  read request to instruction memory.
REQ-008 mem_addr  out  ADDR_W  read address; always equals pc.
REQ-009 mem_rdata  in  16  instruction word from memory.
REQ-010 mem_valid  in  1  mem_rdata is valid this cycle.
REQ-011 instruction  out  16  registered instruction word presented to the control unit.
REQ-012 run  out  1  one-cycle pulse telling the control unit to start executing instruction.
REQ-013 done  in  1  control unit finished the current instruction.
REQ-014 pc  out  ADDR_W  current program counter.
REQ-015 halted  out  1  high while in HALT.
REQ-016 fetch_err  out  1  high while halted because of a memory timeout.

Function
REQ-017 States SHALL be IDLE, REQ, ISSUE, WAIT_DONE and HALT, with a registered state and registered outputs except mem_req, run, mem_addr and halted, which are decoded from state.
REQ-018 IDLE: if start=1, the block SHALL go to REQ next cycle; otherwise it stays in IDLE.
REQ-019 REQ: mem_req=1 and mem_addr=pc; on mem_valid=1, instruction SHALL load mem_rdata on that edge.
REQ-020 REQ with mem_valid=1: next state SHALL be HALT if mem_rdata=16'hFFFF, else ISSUE; the HALT word is still loaded into instruction but run is never pulsed for it.
REQ-021 ISSUE: run=1 for exactly one cycle, then WAIT_DONE unconditionally.
REQ-022 WAIT_DONE: on done=1, pc SHALL increment by 1 modulo 2^ADDR_W (all-ones wraps to 0); next state REQ if start=1, else IDLE.
REQ-023 done outside WAIT_DONE and mem_valid outside REQ SHALL be ignored.
REQ-024 instruction SHALL remain stable from ISSUE through the cycle done is sampled.
REQ-025 Deassertion of start SHALL take effect only in IDLE or at the end of WAIT_DONE; an in-flight REQ or ISSUE completes.
REQ-026 HALT SHALL be left only by reset; halted=1 and run=0 and mem_req=0 throughout.
REQ-027 Minimum latency: start high in IDLE at cycle 0, mem_valid in first REQ cycle (cycle 1) -> run=1 in cycle 2.

Reset
REQ-028 With reset=1 on a rising edge: state=IDLE, pc=0, instruction=16'h0000, timeout counter=0, fetch_err=0; therefore mem_req=0, run=0 and halted=0.
REQ-029 Reset SHALL override every state, including mid-REQ, WAIT_DONE and HALT, and an in-flight memory response SHALL be discarded.

Configuration
REQ-030 With macro FETCH_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and increment each REQ cycle without mem_valid; on the TIMEOUT-th such cycle the block SHALL go to HALT and set fetch_err=1.
REQ-031 Without FETCH_TIMEOUT_EN, no counter SHALL exist, fetch_err SHALL be constant 0, and REQ SHALL wait indefinitely.

Verification
REQ-032 Reset, start=1, memory returns 16'h2A01 at addr 0 with zero wait -> mem_req cycle 1, run cycle 2, instruction=16'h2A01, pc=0.
REQ-033 done pulse in WAIT_DONE with start=1 -> pc=1 next cycle, mem_req=1 with mem_addr=1; with start=0 -> IDLE, mem_req=0.
REQ-034 ADDR_W=8, pc=8'hFF, done in WAIT_DONE -> pc=8'h00 and fetch from addr 0.
REQ-035 Memory returns 16'hFFFF -> HALT, halted=1, run never pulsed, later mem_valid/done ignored until reset.
REQ-036 FETCH_TIMEOUT_EN, TIMEOUT=16, mem_valid never asserted -> after 16 REQ cycles HALT, fetch_err=1; build without macro -> mem_req held indefinitely, fetch_err=0.
REQ-037 reset asserted during WAIT_DONE with pc=5 -> next cycle IDLE, pc=0, instruction=0, a late done is ignored.
